bist_controller: RTL and testbench
==================================

# bist_controller

Sequencer for the scan-chain built-in self-test datapath. It drives `scan_en` through repeated shift/capture rounds and gates the pattern LFSR. It compacts the returned `scan_out` stream into a MISR signature and reports pass/fail against a golden signature. It sits between the top-level test enable logic and the LFSR + scan-chain pair, replacing the free-running `scan_en` stimulus used in stand-alone chain bring-up.

## Interface
- `CHAIN_LEN`, 8: flops in the scan chain (≥2).
- `NUM_PATTERNS`, 16: capture rounds per test (≥1).
- `SIG_W`, 8: MISR width (fixed at 8 in this revision).
- `GOLDEN_SIG`, 8'h00: expected final signature.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: launch test; sampled in IDLE and DONE only.
- `scan_out`  in  1: serial output of the scan chain.
- `scan_en`  out  1: 1 = shift, 0 = capture (chain convention).
- `lfsr_en`  out  1: advance the pattern LFSR that feeds `scan_in`.
- `busy`  out  1: test in progress.
- `done`  out  1: test finished; held until next `start` or `rst`.
- `pass`  out  1: valid when `done`; 1 when signature == `GOLDEN_SIG`.
- `signature`  out  SIG_W: current MISR contents.

## Operation
- **FSM states:** IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- **IDLE:** all outputs 0.
  - `start` → SHIFT. This clears `shift_cnt`, `pat_cnt` and `signature`.
- **SHIFT:** `scan_en`=1 and `lfsr_en`=1 for exactly `CHAIN_LEN` cycles.
  - After the last cycle → CAPTURE.
- **CAPTURE:** `scan_en`=0 and `lfsr_en`=0 for 1 cycle. `pat_cnt` increments.
  - If `pat_cnt` reaches `NUM_PATTERNS` → UNLOAD.
  - Otherwise → SHIFT.
- **UNLOAD:** `scan_en`=1 and `lfsr_en`=0 for `CHAIN_LEN` cycles. This flushes the last captured response. Then → COMPARE.
- **COMPARE:** 1 cycle. `pass` is registered as (`signature` == `GOLDEN_SIG`). → DONE.
- **DONE:** `done`=1, `pass` held, `busy`=0.
  - `start` → SHIFT, with the same clearing as IDLE.
- **MISR update:** on every cycle with `scan_en`=1 and `pat_cnt` ≥ 1 (SHIFT after the first capture, and all of UNLOAD).
  - `sig_next` = (`sig` << 1) ^ (`sig[7]` ? POLY : 0) ^ {7'b0, `scan_out`}.
  - POLY = 8'h71 (x^8+x^6+x^5+x^4+1).
  - Compacted bits per test = `NUM_PATTERNS`×`CHAIN_LEN`.
  - The first load is not compacted, because the chain holds reset garbage at that point.
- **Counter widths:**
  - `shift_cnt` is $clog2(`CHAIN_LEN`) bits and wraps to 0 at `CHAIN_LEN`−1.
  - `pat_cnt` is $clog2(`NUM_PATTERNS`+1) bits and never wraps.
- **`start` while `busy`:** ignored.
- **`rst` asserted in any state:** next edge → IDLE; every output and counter returns to 0; a partial signature is discarded.

## Timing
- **Reset values:** `scan_en`=0, `lfsr_en`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0.
- All outputs are registered; none are combinational from inputs.
- **Launch:** `start` high at edge N → `busy`=`scan_en`=`lfsr_en`=1 after edge N.
- **Total busy cycles** = `NUM_PATTERNS`×(`CHAIN_LEN`+1) + `CHAIN_LEN` + 1 (COMPARE).
- **`done` rises** on the edge leaving COMPARE; `pass` is valid on the same edge.
- **`scan_out` sampling:** sampled on the same edge that shifts the chain. The MISR sees the bit presented before that shift.
- **`start` and `rst` high together:** `rst` wins.

## Structure
- **Package `bist_pkg`:**
  - state enum (3-bit encoding).
  - `MISR_POLY` = 8'h71.
  - `SIG_W` default.
- **Sub-module `bist_misr`:** clk, rst, clr, en, din, sig. This is the only natural split; the FSM and counters stay in `bist_controller`.

## Test plan
- **Reset:** hold `rst` 3 cycles mid-SHIFT → all outputs 0 on the next edge; FSM in IDLE.
- **Sequence:** `CHAIN_LEN`=4, `NUM_PATTERNS`=2, one `start` pulse → `scan_en` pattern 1111 0 1111 0 1111. `lfsr_en` is high only in the first 8 shift cycles. `busy` lasts 15 cycles.
- **All-zero response:** `scan_out`=0, `GOLDEN_SIG`=8'h00 → `signature`=8'h00; `done`=1, `pass`=1.
- **All-one response:** `scan_out`=1, same parameters → 8 compaction steps yield 8'hFF. With `GOLDEN_SIG`=8'h00 → `pass`=0.
- **Start handling:**
  - `start` pulsed during UNLOAD → ignored; cycle count unchanged.
  - `start` in DONE → `done` and `pass` clear next edge and a new run begins with `signature`=0.
- **Polynomial feedback:** single `scan_out`=1 on the first compacted cycle, 0 afterwards, `CHAIN_LEN`=4, `NUM_PATTERNS`=2 → `signature`=8'h80 at `done`. This checks that the MSB does not yet trigger feedback.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the scan-chain BIST sequencer and its MISR.
package bist_pkg;

  localparam int unsigned DEF_SIG_W = 8;
  localparam logic [7:0]  MISR_POLY = 8'h71;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // A test is in progress from the first shift through the compare cycle.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_SHIFT) || (s == ST_CAPTURE) || (s == ST_UNLOAD) || (s == ST_COMPARE);
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Single-input MISR compacting the serial scan-chain response into a signature.
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned SIG_W = DEF_SIG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

  // Shift left, fold the departing MSB back through the polynomial, inject din at bit 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], din} ^ (sig[SIG_W-1] ? POLY : '0);
    end
  end

endmodule

// File: rtl/bist_controller.sv
// Scan BIST sequencer: shift/capture rounds, final unload, MISR compaction and
// golden-signature compare.
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned      CHAIN_LEN    = 8,
  parameter int unsigned      NUM_PATTERNS = 16,
  parameter int unsigned      SIG_W        = DEF_SIG_W,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             scan_out,
  output logic             scan_en,
  output logic             lfsr_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned SHIFT_W = $clog2(CHAIN_LEN);
  localparam int unsigned PAT_W   = $clog2(NUM_PATTERNS + 1);

  state_t             state;
  state_t             state_next;
  logic [SHIFT_W-1:0] shift_cnt;
  logic [PAT_W-1:0]   pat_cnt;
  logic               shift_last;
  logic               pat_last;
  logic               launch;
  logic               misr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    shift_last = (shift_cnt == SHIFT_W'(CHAIN_LEN - 1));
    pat_last   = (pat_cnt == PAT_W'(NUM_PATTERNS - 1));
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT:   if (shift_last) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = pat_last ? ST_UNLOAD : ST_SHIFT;
      ST_UNLOAD:  if (shift_last) state_next = ST_COMPARE;
      ST_COMPARE: state_next = ST_DONE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_en   <= 1'b0;
      lfsr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      shift_cnt <= '0;
      pat_cnt   <= '0;
    end else begin
      scan_en <= (state_next == ST_SHIFT) || (state_next == ST_UNLOAD);
      lfsr_en <= (state_next == ST_SHIFT);
      busy    <= is_busy_state(state_next);
      done    <= (state_next == ST_DONE);

      if (state == ST_COMPARE) begin
        pass <= (signature == GOLDEN_SIG);
      end else if (launch) begin
        pass <= 1'b0;
      end

      if (launch) begin
        shift_cnt <= '0;
      end else if ((state == ST_SHIFT) || (state == ST_UNLOAD)) begin
        shift_cnt <= shift_last ? '0 : shift_cnt + SHIFT_W'(1);
      end

      if (launch) begin
        pat_cnt <= '0;
      end else if (state == ST_CAPTURE) begin
        pat_cnt <= pat_cnt + PAT_W'(1);
      end
    end
  end

  // The first load holds reset garbage, so compaction starts after the first capture.
  assign misr_en = scan_en && (pat_cnt != '0);

  bist_misr #(
    .SIG_W (SIG_W)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .en  (misr_en),
    .din (scan_out),
    .sig (signature)
  );

endmodule

// File: tb/tb_bist_controller.sv
// Randomized self-checking bench for bist_controller against a phase-offset reference model.
module tb_bist_controller;

  localparam int unsigned CL       = 4;
  localparam int unsigned NP       = 2;
  localparam logic [7:0]  GOLDEN   = 8'h00;
  localparam int          LOAD_END = NP * (CL + 1);
  localparam int          UNL_END  = LOAD_END + CL;
  localparam int          BUSY_CYC = UNL_END + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       scan_out;
  logic       scan_en;
  logic       lfsr_en;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;

  int errors = 0;
  int checks = 0;

  // Model: m_k is the 1-based cycle offset since launch (0 = idle, BUSY_CYC+1 = done).
  int         m_k = 0;
  logic [7:0] m_sig = 8'h00;
  logic       m_pass = 1'b0;

  logic       launch_done, launch_pass, launch_busy;
  logic [7:0] launch_sig;

  bist_controller #(
    .CHAIN_LEN    (CL),
    .NUM_PATTERNS (NP),
    .SIG_W        (8),
    .GOLDEN_SIG   (GOLDEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .scan_out  (scan_out),
    .scan_en   (scan_en),
    .lfsr_en   (lfsr_en),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  always #5 clk = ~clk;

  function automatic bit exp_se(input int k);
    if (k >= 1 && k <= LOAD_END) return ((k - 1) % (CL + 1)) < CL;
    return (k > LOAD_END) && (k <= UNL_END);
  endfunction

  function automatic bit exp_le(input int k);
    return (k >= 1) && (k <= LOAD_END) && (((k - 1) % (CL + 1)) < CL);
  endfunction

  function automatic bit exp_compact(input int k);
    return exp_se(k) && (k > CL + 1);
  endfunction

  function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic b);
    int v;
    v = int'(s) * 2;
    if (v >= 256) v = (v - 256) ^ 'h71;
    return 8'(v ^ int'(b));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_k    <= 0;
      m_sig  <= 8'h00;
      m_pass <= 1'b0;
    end else if (m_k == 0 || m_k > BUSY_CYC) begin
      if (start) begin
        m_k    <= 1;
        m_sig  <= 8'h00;
        m_pass <= 1'b0;
      end
    end else begin
      if (exp_compact(m_k)) m_sig <= misr_ref(m_sig, scan_out);
      if (m_k == BUSY_CYC) m_pass <= (m_sig == GOLDEN);
      m_k <= m_k + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // mode: 0 all-zero, 1 all-one, 2 single one on first compacted cycle, 3 random.
  task automatic do_run(input int mode, input bit stray, input int kick_at,
                        output int nbusy, output logic [31:0] se_pat, output logic [31:0] le_pat);
    int cyc;
    cyc    = 0;
    nbusy  = 0;
    se_pat = '0;
    le_pat = '0;
    start  = 1'b1;
    @(posedge clk); #1;
    launch_done = done;
    launch_pass = pass;
    launch_busy = busy;
    launch_sig  = signature;
    while (!done && cyc < 200) begin
      cyc++;
      case (mode)
        0:       scan_out = 1'b0;
        1:       scan_out = 1'b1;
        2:       scan_out = (cyc == int'(CL) + 2);
        default: scan_out = 1'($urandom);
      endcase
      start = (kick_at != 0 && cyc == kick_at) || (stray && $urandom_range(0, 9) == 0);
      if (busy) begin
        nbusy++;
        se_pat = {se_pat[30:0], scan_en};
        le_pat = {le_pat[30:0], lfsr_en};
      end
      @(posedge clk); #1;
    end
    start    = 1'b0;
    scan_out = 1'b0;
    chk("run_reaches_done", 32'(done), 32'd1);
  endtask

  int          nb;
  logic [31:0] sp, lp;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    scan_out = 1'b0;
    @(posedge clk);
    fork
      forever begin
        @(negedge clk);
        chk("mon_scan_en",   32'(scan_en),   32'(exp_se(m_k)));
        chk("mon_lfsr_en",   32'(lfsr_en),   32'(exp_le(m_k)));
        chk("mon_busy",      32'(busy),      32'(m_k >= 1 && m_k <= BUSY_CYC));
        chk("mon_done",      32'(done),      32'(m_k == BUSY_CYC + 1));
        chk("mon_pass",      32'(pass),      32'(m_pass));
        chk("mon_signature", 32'(signature), 32'(m_sig));
      end
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_scan_en", 32'(scan_en), 32'd0);
    chk("rst_lfsr_en", 32'(lfsr_en), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_pass",    32'(pass),    32'd0);
    chk("rst_sig",     32'(signature), 32'd0);

    // Reset in the middle of the second shift round, with a partial signature built up.
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    scan_out = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_sig", 32'(signature), 32'h03);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_scan_en", 32'(scan_en), 32'd0);
    chk("midrst_lfsr_en", 32'(lfsr_en), 32'd0);
    chk("midrst_busy",    32'(busy),    32'd0);
    chk("midrst_sig",     32'(signature), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    scan_out = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_rst_busy",    32'(busy),    32'd0);
    chk("idle_after_rst_scan_en", 32'(scan_en), 32'd0);

    // All-one response, with a stray start in the middle of UNLOAD.
    do_run(1, 1'b0, LOAD_END + 2, nb, sp, lp);
    chk("ones_busy_cycles", 32'(nb), 32'd15);
    chk("ones_scan_en_pat", sp, 32'b111101111011110);
    chk("ones_lfsr_en_pat", lp, 32'b111101111000000);
    chk("ones_sig",  32'(signature), 32'hFF);
    chk("ones_pass", 32'(pass), 32'd0);

    // All-zero response, launched from DONE with a nonzero signature pending.
    do_run(0, 1'b0, 0, nb, sp, lp);
    chk("zeros_launch_done", 32'(launch_done), 32'd0);
    chk("zeros_launch_sig",  32'(launch_sig),  32'd0);
    chk("zeros_launch_busy", 32'(launch_busy), 32'd1);
    chk("zeros_busy_cycles", 32'(nb), 32'd15);
    chk("zeros_sig",  32'(signature), 32'h00);
    chk("zeros_pass", 32'(pass), 32'd1);
    chk("zeros_done", 32'(done), 32'd1);

    // Single one on the first compacted bit: walks to the MSB without feedback.
    do_run(2, 1'b0, 0, nb, sp, lp);
    chk("poly_launch_pass", 32'(launch_pass), 32'd0);
    chk("poly_launch_done", 32'(launch_done), 32'd0);
    chk("poly_sig",  32'(signature), 32'h80);
    chk("poly_pass", 32'(pass), 32'd0);

    for (int r = 0; r < 10; r++) begin
      do_run(3, 1'b1, 0, nb, sp, lp);
      chk("rand_busy_cycles", 32'(nb), 32'(BUSY_CYC));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
